argmax_classifier: RTL and testbench

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

---
 rtl/argmax_classifier_if.sv | 29 ++
 rtl/argmax_classifier.sv | 106 ++++++++++
 tb/tb_argmax_classifier.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/argmax_classifier_if.sv
`default_nettype none
// ============================================================================
//  Module   : argmax_classifier_if
//  Brief    : Score stream in, classification result out, for argmax_classifier.
//  Revision : 1.0
// ============================================================================
interface argmax_classifier_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic [3:0]            class_out;
  logic [DATA_WIDTH-1:0] max_out;
  logic [DATA_WIDTH-1:0] margin_out;
  logic                  valid_out;
  logic                  busy;
  logic [7:0]            frame_cnt;

  modport master (
    output valid_in, data_in,
    input  class_out, max_out, margin_out, valid_out, busy, frame_cnt
  );

  modport slave (
    input  valid_in, data_in,
    output class_out, max_out, margin_out, valid_out, busy, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/argmax_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : argmax_classifier
//  Brief    : Streaming argmax over NUM_CLASSES unsigned scores per frame,
//             reporting winning class, winning score and top-2 margin.
//  Revision : 1.0
// ============================================================================
module argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 12
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  argmax_classifier_if.slave  bus
);

  localparam logic [3:0] c_LAST_IDX = 4'(NUM_CLASSES - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                r_state;
  logic [3:0]            r_idx;
  logic [DATA_WIDTH-1:0] r_max;
  logic [DATA_WIDTH-1:0] r_second;
  logic [3:0]            r_best;
  logic [3:0]            r_class;
  logic [DATA_WIDTH-1:0] r_max_out;
  logic [DATA_WIDTH-1:0] r_margin;
  logic                  r_valid_out;
  logic                  r_busy;
  logic [7:0]            r_frame_cnt;

  logic [DATA_WIDTH-1:0] w_max;
  logic [DATA_WIDTH-1:0] w_second;
  logic [3:0]            w_best;
  logic                  w_last;

  // Running top-2 including the score on the bus this cycle, so the last
  // score of a frame is folded in without an extra cycle.
  always_comb begin
    w_max    = r_max;
    w_second = r_second;
    w_best   = r_best;
    w_last   = (r_idx == c_LAST_IDX);
    if (r_idx == 4'd0) begin
      w_max    = bus.data_in;
      w_second = '0;
      w_best   = 4'd0;
    end else if (bus.data_in > r_max) begin
      w_second = r_max;
      w_max    = bus.data_in;
      w_best   = r_idx;
    end else if (bus.data_in > r_second) begin
      w_second = bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= 4'd0;
      r_max       <= '0;
      r_second    <= '0;
      r_best      <= 4'd0;
      r_class     <= 4'd0;
      r_max_out   <= '0;
      r_margin    <= '0;
      r_valid_out <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_valid_out <= 1'b0;
      if (bus.valid_in) begin
        r_max    <= w_max;
        r_second <= w_second;
        r_best   <= w_best;
        if (w_last) begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_idx       <= 4'd0;
          r_class     <= w_best;
          r_max_out   <= w_max;
          r_margin    <= w_max - w_second;
          r_valid_out <= 1'b1;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
          r_state <= ACCUM;
          r_busy  <= 1'b1;
          r_idx   <= r_idx + 4'd1;
        end
      end
    end
  end

  assign bus.class_out  = r_class;
  assign bus.max_out    = r_max_out;
  assign bus.margin_out = r_margin;
  assign bus.valid_out  = r_valid_out;
  assign bus.busy       = r_busy;
  assign bus.frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_argmax_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_argmax_classifier
//  Brief    : Self-checking bench for argmax_classifier against a top-2 model.
//  Revision : 1.0
// ============================================================================
module tb_argmax_classifier;

  localparam int NC = 10;
  localparam int DW = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  argmax_classifier_if #(.DATA_WIDTH(DW)) ifc ();

  argmax_classifier #(
    .NUM_CLASSES(NC),
    .DATA_WIDTH (DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference: winner is the first index holding the largest value, runner-up
  // is the largest value among all other positions.
  function automatic void ref_argmax(input logic [DW-1:0] s[NC],
                                     output int cls, output int mx, output int mar);
    int sec;
    cls = 0;
    for (int i = 1; i < NC; i++) if (s[i] > s[cls]) cls = i;
    mx  = int'(s[cls]);
    sec = 0;
    for (int i = 0; i < NC; i++) if (i != cls && int'(s[i]) > sec) sec = int'(s[i]);
    mar = mx - sec;
  endfunction

  logic [DW-1:0] fr[NC];
  int  taken = 0;
  int  m_cls = 0, m_max = 0, m_mar = 0, m_fc = 0;
  bit  m_pulse = 1'b0;
  bit  mon_en  = 1'b0;
  int  cyc_n   = 0;
  int  pulse_cyc[$];

  always @(posedge clk) begin
    cyc_n++;
    m_pulse = 1'b0;
    if (!rst_n) begin
      taken = 0; m_cls = 0; m_max = 0; m_mar = 0; m_fc = 0;
    end else if (ifc.valid_in) begin
      fr[taken] = ifc.data_in;
      taken++;
      if (taken == NC) begin
        ref_argmax(fr, m_cls, m_max, m_mar);
        m_pulse = 1'b1;
        m_fc    = (m_fc + 1) % 256;
        taken   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("valid_out",  ifc.valid_out,  m_pulse);
      check("busy",       ifc.busy,       taken != 0);
      check("class_out",  ifc.class_out,  m_cls);
      check("max_out",    ifc.max_out,    m_max);
      check("margin_out", ifc.margin_out, m_mar);
      check("frame_cnt",  ifc.frame_cnt,  m_fc);
      if (ifc.valid_out) pulse_cyc.push_back(cyc_n);
    end
  end

  task automatic cyc(input bit v, input logic [DW-1:0] d);
    ifc.valid_in = v;
    ifc.data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, DW'($urandom));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) cyc(1'b1, DW'($urandom));
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [DW-1:0] f[NC], input int maxgap);
    for (int i = 0; i < NC; i++) begin
      idle(int'($urandom_range(0, maxgap)));
      cyc(1'b1, f[i]);
    end
  endtask

  task automatic expect_result(input string tag, input int cls, input int mx,
                               input int mar, input int fc);
    check({tag, "_valid"},  ifc.valid_out,  1);
    check({tag, "_class"},  ifc.class_out,  cls);
    check({tag, "_max"},    ifc.max_out,    mx);
    check({tag, "_margin"}, ifc.margin_out, mar);
    check({tag, "_fcnt"},   ifc.frame_cnt,  fc);
  endtask

  logic [DW-1:0] f_main[NC] = '{5, 9, 3, 20, 7, 1, 0, 11, 2, 4};
  logic [DW-1:0] f_tie[NC]  = '{0, 0, 50, 0, 50, 0, 0, 0, 0, 0};
  logic [DW-1:0] f_zero[NC] = '{default: '0};
  logic [DW-1:0] f_b[NC];
  logic [DW-1:0] f_r[NC];

  initial begin
    int p0;
    ifc.valid_in = 1'b0;
    ifc.data_in  = '0;
    #1;
    do_reset(3);
    mon_en = 1'b1;
    check("rst_class",  ifc.class_out,  0);
    check("rst_max",    ifc.max_out,    0);
    check("rst_margin", ifc.margin_out, 0);
    check("rst_valid",  ifc.valid_out,  0);
    check("rst_busy",   ifc.busy,       0);
    check("rst_fcnt",   ifc.frame_cnt,  0);

    send_frame(f_main, 0);
    expect_result("basic", 3, 20, 9, 1);
    idle(3);

    send_frame(f_tie, 0);
    expect_result("tie", 2, 50, 0, 2);
    idle(2);

    p0 = pulse_cyc.size();
    send_frame(f_zero, 0);
    expect_result("zero", 0, 0, 0, 3);
    idle(4);
    check("zero_pulses", pulse_cyc.size() - p0, 1);

    send_frame(f_main, 5);
    expect_result("gaps", 3, 20, 9, 4);
    idle(2);

    // Back-to-back: second frame starts in the cycle the first result pulses.
    do_reset(2);
    for (int i = 0; i < NC - 1; i++) f_b[i] = DW'($urandom_range(0, 99));
    f_b[$urandom_range(0, NC - 2)] = DW'(100);
    f_b[NC-1] = DW'(4095);
    send_frame(f_main, 0);
    expect_result("b2b_a", 3, 20, 9, 1);
    send_frame(f_b, 0);
    expect_result("b2b_b", 9, 4095, 3995, 2);
    idle(1);
    check("b2b_spacing", pulse_cyc[$] - pulse_cyc[$-1], 10);

    p0 = pulse_cyc.size();
    for (int i = 0; i < 6; i++) cyc(1'b1, DW'($urandom));
    do_reset(2);
    send_frame(f_tie, 0);
    expect_result("midrst", 2, 50, 0, 1);
    idle(2);
    check("midrst_pulses", pulse_cyc.size() - p0, 1);

    // Random frames; narrow value range every third frame to force ties.
    for (int k = 0; k < 270; k++) begin
      for (int i = 0; i < NC; i++)
        f_r[i] = DW'($urandom_range(0, (k % 3 == 0) ? 3 : 4095));
      send_frame(f_r, (k % 4 == 0) ? 3 : 0);
      if (k % 5 == 0) idle(int'($urandom_range(0, 4)));
    end
    idle(3);
    check("fcnt_wrap", ifc.frame_cnt, (1 + 270) % 256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
